// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: opcodes, load modes and the
// write-buffer entry layout.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_AW     = 5;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_LHU     = 6'b100101;

    typedef enum logic [2:0] {
        LM_WORD,
        LM_BYTE,
        LM_BYTE_U,
        LM_HALF,
        LM_HALF_U
    } load_mode_t;

    typedef struct packed {
        logic [WB_AW-1:0]     addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    // Immediate ALU group (ADDI, SLTI, ANDI, ORI, LUI, ...) writes rt.
    function automatic logic is_imm_alu(input logic [5:0] op);
        return op[5:3] == 3'b001;
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// Little-endian byte/halfword extraction with sign or zero extension for loads.
module wb_load_align
    import wb_pkg::*;
(
    input  logic [31:0] lmd,
    input  logic [1:0]  off,
    input  load_mode_t  mode,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = lmd[7:0];
        case (off)
            2'd0:    byte_sel = lmd[7:0];
            2'd1:    byte_sel = lmd[15:8];
            2'd2:    byte_sel = lmd[23:16];
            default: byte_sel = lmd[31:24];
        endcase
        // Halfword accesses only look at off[1]; misaligned low bit is ignored.
        half_sel = off[1] ? lmd[31:16] : lmd[15:0];
    end

    always_comb begin
        data = lmd;
        case (mode)
            LM_BYTE:   data = {{24{byte_sel[7]}}, byte_sel};
            LM_BYTE_U: data = {24'd0, byte_sel};
            LM_HALF:   data = {{16{half_sel[15]}}, half_sel};
            LM_HALF_U: data = {16'd0, half_sel};
            default:   data = lmd;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: decodes the destination of each retiring instruction, queues
// register writes in a small FIFO and drains them to the regfile port.
module wb_stage
    import wb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int AW       = 5,
    parameter int DEPTH    = 2,
    parameter int CNT_W    = 16,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       ir_i,
    input  logic [DATA_W-1:0] lmd_i,
    input  logic [DATA_W-1:0] aluo_i,
    input  logic [DATA_W-1:0] link_i,
    input  logic              wb_ready,
    input  logic              flush,
    input  logic [AW-1:0]     fwd_addr,
    output logic              in_ready,
    output logic              wb_write,
    output logic [AW-1:0]     wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = IW + 1;

    if (DATA_W != 32) begin : g_bad_data_w
        $error("wb_stage: DATA_W must be 32");
    end
    if (AW != WB_AW) begin : g_bad_aw
        $error("wb_stage: AW must match the buffer entry address width");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("wb_stage: DEPTH must be a power of two and at least 2");
    end

    logic [5:0]        op;
    logic              dec_write;
    logic [AW-1:0]     dec_addr;
    logic [DATA_W-1:0] dec_data;
    logic              dec_is_load;
    load_mode_t        dec_mode;
    logic [DATA_W-1:0] load_data;

    assign op = ir_i[31:26];

    always_comb begin
        dec_write   = 1'b0;
        dec_addr    = '0;
        dec_is_load = 1'b0;
        dec_mode    = LM_WORD;
        if (op == OP_SPECIAL) begin
            dec_write = (ir_i != 32'd0);
            dec_addr  = ir_i[15:11];
        end else if (is_imm_alu(op)) begin
            dec_write = 1'b1;
            dec_addr  = ir_i[20:16];
        end else if (op == OP_JAL) begin
            dec_write = 1'b1;
            dec_addr  = AW'(LINK_REG);
        end else begin
            dec_addr = ir_i[20:16];
            case (op)
                OP_LB:   begin dec_write = 1'b1; dec_is_load = 1'b1; dec_mode = LM_BYTE;   end
                OP_LBU:  begin dec_write = 1'b1; dec_is_load = 1'b1; dec_mode = LM_BYTE_U; end
                OP_LH:   begin dec_write = 1'b1; dec_is_load = 1'b1; dec_mode = LM_HALF;   end
                OP_LHU:  begin dec_write = 1'b1; dec_is_load = 1'b1; dec_mode = LM_HALF_U; end
                OP_LW:   begin dec_write = 1'b1; dec_is_load = 1'b1; dec_mode = LM_WORD;   end
                default: dec_write = 1'b0;
            endcase
        end
        // r0 is hardwired, so writes to it never reach the buffer.
        if (dec_addr == '0) begin
            dec_write = 1'b0;
        end
    end

    wb_load_align u_load_align (
        .lmd  (lmd_i),
        .off  (aluo_i[1:0]),
        .mode (dec_mode),
        .data (load_data)
    );

    always_comb begin
        dec_data = aluo_i;
        if (op == OP_JAL) begin
            dec_data = link_i;
        end else if (dec_is_load) begin
            dec_data = load_data;
        end
    end

    wb_entry_t     buf_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic          empty;
    logic          accept;
    logic          push;
    logic          pop;
    wb_entry_t     head;

    assign count    = wr_ptr - rd_ptr;
    assign empty    = (count == '0);
    assign in_ready = (count < PW'(DEPTH)) && !flush;
    assign accept   = in_valid && in_ready;
    assign push     = accept && dec_write;
    assign pop      = !empty && wb_ready && !flush;
    assign head     = buf_mem[rd_ptr[IW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr[IW-1:0]] <= '{addr: dec_addr, data: dec_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wb_write   <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            retire_cnt <= '0;
        end else begin
            if (accept) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                wb_write <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr  <= rd_ptr + PW'(1);
                    wb_addr <= head.addr;
                    wb_data <= head.data;
                end
                wb_write <= pop;
            end
        end
    end

    logic [PW-1:0] fwd_idx;

    // Scan oldest to youngest so the last match wins; the output register is
    // older than anything still buffered.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        if (fwd_addr != '0) begin
            if (wb_write && (wb_addr == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                fwd_idx = rd_ptr + PW'(i);
                if ((PW'(i) < count) && (buf_mem[fwd_idx[IW-1:0]].addr == fwd_addr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = buf_mem[fwd_idx[IW-1:0]].data;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: decode, load alignment, buffering, forwarding,
// flush and asynchronous reset.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] ir_i;
    logic [31:0] lmd_i;
    logic [31:0] aluo_i;
    logic [31:0] link_i;
    logic        wb_ready;
    logic        flush;
    logic [4:0]  fwd_addr;
    logic        in_ready;
    logic        wb_write;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [15:0] retire_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    wb_stage #(
        .DATA_W   (32),
        .AW       (5),
        .DEPTH    (2),
        .CNT_W    (16),
        .LINK_REG (31)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .ir_i       (ir_i),
        .lmd_i      (lmd_i),
        .aluo_i     (aluo_i),
        .link_i     (link_i),
        .wb_ready   (wb_ready),
        .flush      (flush),
        .fwd_addr   (fwd_addr),
        .in_ready   (in_ready),
        .wb_write   (wb_write),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ir, input logic [31:0] aluo,
                         input logic [31:0] lmd, input logic [31:0] link);
        in_valid = 1'b1;
        ir_i     = ir;
        aluo_i   = aluo;
        lmd_i    = lmd;
        link_i   = link;
        tick();
        in_valid = 1'b0;
        exp_cnt++;
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        ir_i     = '0;
        lmd_i    = '0;
        aluo_i   = '0;
        link_i   = '0;
        wb_ready = 1'b0;
        flush    = 1'b0;
        fwd_addr = 5'd2;
        #2;
        check("rst_wb_write", wb_write, 0);
        check("rst_wb_addr", wb_addr, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_retire", retire_cnt, 0);
        check("rst_fwd_hit", fwd_hit, 0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);

        // R-type ADD to r2 with minimum latency
        wb_ready = 1'b1;
        issue(32'h0000_1020, 32'd456, 32'd0, 32'd0);
        check("add_retire", retire_cnt, 1);
        check("add_not_yet", wb_write, 0);
        check("add_fwd_buf_hit", fwd_hit, 1);
        check("add_fwd_buf_data", fwd_data, 32'd456);
        tick();
        check("add_write", wb_write, 1);
        check("add_addr", wb_addr, 2);
        check("add_data", wb_data, 32'd456);
        check("add_fwd_out_hit", fwd_hit, 1);
        tick();
        check("add_write_off", wb_write, 0);
        check("add_addr_hold", wb_addr, 2);
        check("add_fwd_gone", fwd_hit, 0);
        fwd_addr = 5'd0;

        // Loads through the aligner
        issue(32'h8005_0000, 32'd0, 32'h1234_5680, 32'd0);
        tick();
        check("lb_write", wb_write, 1);
        check("lb_addr", wb_addr, 5);
        check("lb_data", wb_data, 32'hFFFF_FF80);
        issue(32'h9005_0000, 32'd0, 32'h1234_5680, 32'd0);
        tick();
        check("lbu_data", wb_data, 32'h0000_0080);
        issue(32'h8405_0000, 32'd2, 32'h8001_0000, 32'd0);
        tick();
        check("lh_data", wb_data, 32'hFFFF_8001);
        issue(32'h8C07_0000, 32'd3, 32'hDEAD_BEEF, 32'd0);
        tick();
        check("lw_addr", wb_addr, 7);
        check("lw_data", wb_data, 32'hDEAD_BEEF);
        issue(32'h9406_0000, 32'd3, 32'h8001_0000, 32'd0);
        tick();
        check("lhu_addr", wb_addr, 6);
        check("lhu_data", wb_data, 32'h0000_8001);
        issue(32'h9004_0000, 32'd1, 32'h0000_AB00, 32'd0);
        tick();
        check("lbu_off1_data", wb_data, 32'h0000_00AB);

        // Non-writing instructions still retire
        in_valid = 1'b1;
        ir_i = 32'hAC00_0000;
        tick();
        check("sw_no_write", wb_write, 0);
        ir_i = 32'h2000_0005;
        tick();
        check("addi_r0_no_write", wb_write, 0);
        ir_i = 32'h0000_0000;
        tick();
        check("nop_no_write", wb_write, 0);
        in_valid = 1'b0;
        exp_cnt += 3;
        tick();
        check("nonwr_no_write", wb_write, 0);
        check("nonwr_retire", retire_cnt, exp_cnt);

        issue(32'h0C00_0000, 32'd0, 32'd0, 32'h0000_0400);
        tick();
        check("jal_write", wb_write, 1);
        check("jal_addr", wb_addr, 31);
        check("jal_data", wb_data, 32'h0000_0400);

        // Back-pressure with three ADDIs into a two-entry buffer
        wb_ready = 1'b0;
        in_valid = 1'b1;
        ir_i = 32'h2001_0000; aluo_i = 32'h111;
        tick();
        ir_i = 32'h2002_0000; aluo_i = 32'h222;
        tick();
        check("full_in_ready", in_ready, 0);
        ir_i = 32'h2003_0000; aluo_i = 32'h333;
        fwd_addr = 5'd2;
        #1;
        check("stall_fwd2_hit", fwd_hit, 1);
        check("stall_fwd2_data", fwd_data, 32'h222);
        fwd_addr = 5'd1;
        #1;
        check("stall_fwd1_data", fwd_data, 32'h111);
        tick();
        check("stall_no_write", wb_write, 0);
        check("stall_retire", retire_cnt, exp_cnt + 2);
        wb_ready = 1'b1;
        tick();
        check("drain1_write", wb_write, 1);
        check("drain1_addr", wb_addr, 1);
        check("drain1_data", wb_data, 32'h111);
        check("drain1_fwd_out", fwd_data, 32'h111);
        check("drain1_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("drain2_write", wb_write, 1);
        check("drain2_addr", wb_addr, 2);
        check("drain2_data", wb_data, 32'h222);
        tick();
        check("drain3_write", wb_write, 1);
        check("drain3_addr", wb_addr, 3);
        check("drain3_data", wb_data, 32'h333);
        tick();
        check("drain_done", wb_write, 0);
        exp_cnt += 3;
        check("drain_retire", retire_cnt, exp_cnt);

        // Youngest match wins, then asynchronous reset mid-cycle
        wb_ready = 1'b0;
        issue(32'h2004_0000, 32'h0000_000A, 32'd0, 32'd0);
        issue(32'h2004_0000, 32'h0000_000B, 32'd0, 32'd0);
        fwd_addr = 5'd4;
        #1;
        check("young_fwd_hit", fwd_hit, 1);
        check("young_fwd_data", fwd_data, 32'h0000_000B);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_write", wb_write, 0);
        check("mid_rst_addr", wb_addr, 0);
        check("mid_rst_retire", retire_cnt, 0);
        check("mid_rst_fwd", fwd_hit, 0);
        rst = 1'b1;
        exp_cnt = 0;
        wb_ready = 1'b1;
        tick();
        check("post_rst_no_commit1", wb_write, 0);
        tick();
        check("post_rst_no_commit2", wb_write, 0);

        // Flush with two buffered writes
        wb_ready = 1'b0;
        issue(32'h2005_0000, 32'h55, 32'd0, 32'd0);
        issue(32'h2006_0000, 32'h66, 32'd0, 32'd0);
        in_valid = 1'b1;
        ir_i = 32'h2007_0000; aluo_i = 32'h77;
        flush = 1'b1;
        wb_ready = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        fwd_addr = 5'd5;
        #1;
        check("flush_write", wb_write, 0);
        check("flush_retire", retire_cnt, exp_cnt);
        check("flush_in_ready_after", in_ready, 1);
        check("flush_fwd", fwd_hit, 0);
        tick();
        check("flush_no_commit1", wb_write, 0);
        tick();
        check("flush_no_commit2", wb_write, 0);

        issue(32'h0000_3020, 32'h99, 32'd0, 32'd0);
        tick();
        check("after_flush_write", wb_write, 1);
        check("after_flush_addr", wb_addr, 6);
        check("after_flush_data", wb_data, 32'h99);
        check("after_flush_retire", retire_cnt, exp_cnt);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
